// File: rtl/i2c_target_regs.sv
// ============================================================================
// Module      : i2c_target_regs
// Description : I2C target with a byte-wide register file, pointer
//               auto-increment and repeated START / STOP handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         ADDR_W      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_o,
  output logic                       sda_t,
  output logic [8*(2**ADDR_W)-1:0]   regs_o,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       busy,
  output logic                       stop_det
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DADDR, ST_MADDR, ST_WDATA, ST_ACK, ST_RDATA, ST_RACK, ST_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0]     scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                       scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  state_t                     state_q, state_d, ack_to_q, ack_to_d;
  logic                       ack_ph_q, ack_ph_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [7:0]                 shift_q, shift_d;
  logic [ADDR_W-1:0]          ptr_q, ptr_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic                       sda_t_q, sda_t_d, busy_q, busy_d;
  logic                       stop_det_q, stop_det_d, wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]                 wr_data_q, wr_data_d;

  logic       scl_s, sda_s, scl_re, scl_fe, start_c, stop_c;
  logic [7:0] rx_byte;

  assign scl_s   = scl_sync_q[SYNC_STAGES-1];
  assign sda_s   = sda_sync_q[SYNC_STAGES-1];
  assign scl_re  = scl_s & ~scl_hist_q;
  assign scl_fe  = ~scl_s & scl_hist_q;
  assign start_c = scl_s & sda_hist_q & ~sda_s;
  assign stop_c  = scl_s & ~sda_hist_q & sda_s;
  assign rx_byte = {shift_q[6:0], sda_s};

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
    state_d    = state_q;
    ack_to_d   = ack_to_q;
    ack_ph_d   = ack_ph_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    sda_t_d    = sda_t_q;
    busy_d     = busy_q;
    stop_det_d = 1'b0;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // Bus conditions override any SCL-edge activity in the same cycle.
    if (stop_c) begin
      state_d    = ST_IDLE;
      cnt_d      = 3'd0;
      sda_t_d    = 1'b1;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_c) begin
      state_d = ST_DADDR;
      cnt_d   = 3'd0;
      sda_t_d = 1'b1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_DADDR, ST_MADDR, ST_WDATA: begin
          if (scl_re) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d  = ST_ACK;
              ack_ph_d = 1'b0;
              ack_to_d = ST_WDATA;
              if (state_q == ST_DADDR) begin
                if (rx_byte[7:1] == DEV_ADDR)
                  ack_to_d = rx_byte[0] ? ST_RDATA : ST_MADDR;
                else
                  state_d = ST_IDLE;
              end else if (state_q == ST_MADDR) begin
                ptr_d = rx_byte[ADDR_W-1:0];
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_stb_d      = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_q + PTR_ONE;
              end
            end
          end
        end
        ST_ACK: begin
          // Phase 0 waits for the end of bit 8; phase 1 holds ACK through bit 9.
          if (scl_fe) begin
            if (!ack_ph_q) begin
              sda_t_d  = 1'b0;
              ack_ph_d = 1'b1;
            end else begin
              state_d = ack_to_q;
              cnt_d   = 3'd0;
              sda_t_d = 1'b1;
              if (ack_to_q == ST_RDATA) begin
                shift_d = regs_q[ptr_q];
                sda_t_d = regs_q[ptr_q][7];
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fe) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_t_d  = 1'b1;
              state_d  = ST_RACK;
              ack_ph_d = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], shift_q[7]};
              sda_t_d = shift_q[6];
            end
          end
        end
        ST_RACK: begin
          if (scl_re) begin
            ptr_d = ptr_q + PTR_ONE;
            if (sda_s) state_d = ST_WAIT;
            else       ack_ph_d = 1'b1;
          end else if (scl_fe && ack_ph_q) begin
            state_d = ST_RDATA;
            cnt_d   = 3'd0;
            shift_d = regs_q[ptr_q];
            sda_t_d = regs_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= ST_IDLE;
      ack_to_q   <= ST_IDLE;
      ack_ph_q   <= 1'b0;
      cnt_q      <= 3'd0;
      shift_q    <= 8'd0;
      ptr_q      <= '0;
      regs_q     <= '0;
      sda_t_q    <= 1'b1;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      ack_to_q   <= ack_to_d;
      ack_ph_q   <= ack_ph_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      regs_q     <= regs_d;
      sda_t_q    <= sda_t_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign sda_o    = 1'b0;
  assign sda_t    = sda_t_q;
  assign regs_o   = regs_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign stop_det = stop_det_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
// ============================================================================
// Module      : tb_i2c_target_regs
// Description : Bus-level master driving i2c_target_regs against a register
//               file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_target_regs;

  localparam int Q = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic bus_sda;
  logic sda_o, sda_t, wr_stb, busy, stop_det;
  logic [127:0] regs_o;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mregs [16];
  int          mptr;
  logic [7:0]  wq [$];
  logic [11:0] wr_log [$];
  int          stop_cnt = 0;

  // Open-drain bus: the target can only pull low.
  assign bus_sda = sda_m & (sda_t ? 1'b1 : sda_o);

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(bus_sda),
    .sda_o(sda_o), .sda_t(sda_t), .regs_o(regs_o),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) wr_log.push_back({wr_addr, wr_data});
    if (stop_det) stop_cnt <= stop_cnt + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    sda_m = b;  wait_q();
    scl_m = 1'b1; wait_q();
    s = bus_sda; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic do_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic do_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic mack);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, s);
      d = {d[6:0], s};
    end
    bit_io(mack, s);
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  // Write transaction: device address, register pointer, then bytes in wq.
  task automatic tx_write(input logic [6:0] dev, input logic [7:0] maddr, input string tag);
    logic a;
    logic [11:0] exp_log [$];
    int base = wr_log.size();
    int st0  = stop_cnt;
    bit hit  = (dev == 7'h50);
    do_start();
    chk($sformatf("%s_busy", tag), busy, 1);
    wbyte({dev, 1'b0}, a);
    chk($sformatf("%s_dack", tag), a, hit ? 0 : 1);
    wbyte(maddr, a);
    chk($sformatf("%s_mack", tag), a, hit ? 0 : 1);
    if (hit) mptr = int'(maddr[3:0]);
    foreach (wq[i]) begin
      wbyte(wq[i], a);
      chk($sformatf("%s_wack%0d", tag, i), a, hit ? 0 : 1);
      if (hit) begin
        mregs[mptr] = wq[i];
        exp_log.push_back({4'(mptr), wq[i]});
        mptr = (mptr + 1) % 16;
      end
    end
    chk($sformatf("%s_busy_hold", tag), busy, 1);
    do_stop(); wait_q();
    chk($sformatf("%s_stopdet", tag), stop_cnt, st0 + 1);
    chk($sformatf("%s_idle", tag), busy, 0);
    chk($sformatf("%s_nwr", tag), wr_log.size() - base, exp_log.size());
    foreach (exp_log[i])
      if (base + i < wr_log.size())
        chk($sformatf("%s_wr%0d", tag, i), wr_log[base + i], exp_log[i]);
    chk($sformatf("%s_regs", tag), regs_o, model_flat());
  endtask

  // Read transaction, optionally setting the pointer first via repeated START.
  task automatic tx_read(input bit set_ptr, input logic [7:0] maddr, input int n, input string tag);
    logic a;
    logic [7:0] d;
    do_start();
    if (set_ptr) begin
      wbyte(8'hA0, a); chk($sformatf("%s_wdack", tag), a, 0);
      wbyte(maddr, a); chk($sformatf("%s_mack", tag), a, 0);
      mptr = int'(maddr[3:0]);
      do_rstart();
    end
    wbyte(8'hA1, a); chk($sformatf("%s_rdack", tag), a, 0);
    for (int i = 0; i < n; i++) begin
      rbyte(d, (i == n - 1));
      chk($sformatf("%s_rd%0d", tag, i), d, mregs[mptr]);
      mptr = (mptr + 1) % 16;
    end
    do_stop(); wait_q();
    chk($sformatf("%s_idle", tag), busy, 0);
    chk($sformatf("%s_regs", tag), regs_o, model_flat());
  endtask

  initial begin
    logic a, s;
    int base, st0;
    logic [6:0] dev;

    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;

    repeat (4) @(negedge clk);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs", regs_o, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_stop_det", stop_det, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b1;
    wait_q();

    wq = '{8'h11, 8'h22, 8'h33};
    tx_write(7'h50, 8'h02, "burst");

    wq = '{8'h99};
    tx_write(7'h51, 8'h05, "mismatch");

    tx_read(1'b1, 8'h03, 2, "rd_sr");
    tx_read(1'b0, 8'h00, 1, "rd_ptr5");

    wq = '{8'hAA, 8'hBB};
    tx_write(7'h50, 8'h0F, "wrap");

    // Abort a data byte after four bits; the pointer must be retained.
    wq = '{8'hC3, 8'h5A};
    tx_write(7'h50, 8'h06, "pre_part");
    base = wr_log.size();
    st0  = stop_cnt;
    do_start();
    wbyte(8'hA0, a); chk("part_dack", a, 0);
    wbyte(8'h06, a); chk("part_mack", a, 0);
    mptr = 6;
    bit_io(1'b1, s); bit_io(1'b0, s); bit_io(1'b1, s); bit_io(1'b0, s);
    do_stop(); wait_q();
    chk("part_nwr", wr_log.size() - base, 0);
    chk("part_stopdet", stop_cnt, st0 + 1);
    chk("part_idle", busy, 0);
    chk("part_regs", regs_o, model_flat());
    tx_read(1'b0, 8'h00, 2, "after_part");

    // Reset while the target is pulling SDA low for a data bit.
    wq = '{8'h3C};
    tx_write(7'h50, 8'h09, "pre_rst");
    do_start();
    wbyte(8'hA0, a); chk("rstrd_dack", a, 0);
    wbyte(8'h09, a); chk("rstrd_mack", a, 0);
    do_rstart();
    wbyte(8'hA1, a); chk("rstrd_rdack", a, 0);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    chk("rstrd_driving", bus_sda, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstrd_sda_t", sda_t, 1);
    chk("rstrd_regs", regs_o, 0);
    chk("rstrd_busy", busy, 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    wait_q();
    scl_m = 1'b0; wait_q();
    do_stop(); wait_q();
    wq = '{8'h77, 8'h12};
    tx_write(7'h50, 8'h01, "post_rst");
    tx_read(1'b1, 8'h01, 2, "post_rst_rd");

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          dev = 7'h50;
          if ($urandom_range(0, 5) == 0) begin
            dev = 7'($urandom_range(0, 127));
            if (dev == 7'h50) dev = 7'h51;
          end
          wq.delete();
          for (int k = $urandom_range(0, 4); k > 0; k--) wq.push_back(8'($urandom));
          tx_write(dev, 8'($urandom), $sformatf("rnd%0d_w", t));
        end
        1: tx_read(1'b1, 8'($urandom), $urandom_range(1, 4), $sformatf("rnd%0d_r", t));
        default: tx_read(1'b0, 8'h00, $urandom_range(1, 3), $sformatf("rnd%0d_c", t));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
Parametrised I2C target (slave) with an internal byte-wide register file. It supports addressed multi-byte writes and reads with pointer auto-increment, repeated START and STOP detection. The target drives ACK and read data on SDA open-drain. It sits on the board I2C bus as a configuration/status register target, oversampling SCL/SDA in the fabric clock domain.

Parameters:
DEV_ADDR, 7'h50, 7-bit target address matched against the first byte after START.
ADDR_W, 4, register pointer width; NUM_REGS = 2**ADDR_W byte registers.
SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (min 2).

Ports:
clk  input  1  fabric clock, at least 16x SCL rate.
rst  input  1  synchronous, active-low reset.
scl_i  input  1  SCL pad input.
sda_i  input  1  SDA pad input.
sda_o  output  1  SDA output value, constant 0.
sda_t  output  1  SDA tristate: 1 = release (high-Z), 0 = drive low.
regs_o  output  8*NUM_REGS  flat register file, reg[n] at bits [8n+7:8n].
wr_stb  output  1  one-cycle pulse per byte written from the bus.
wr_addr  output  ADDR_W  register index of the current wr_stb.
wr_data  output  8  byte of the current wr_stb.
busy  output  1  high from START to STOP.
stop_det  output  1  one-cycle pulse on STOP.

Behaviour:
- Reset (rst=0 at clk edge): all regs 0, ptr 0, sda_t=1, wr_stb/stop_det/busy=0, wr_addr/wr_data=0, state IDLE, bit counter 0.
- scl_i/sda_i pass through SYNC_STAGES flops, then one history flop. scl_re/scl_fe = synced SCL 0->1 / 1->0.
- START = synced SDA 1->0 while synced SCL high. STOP = SDA 0->1 while SCL high.
- START in any state (incl. repeated START): go to DADDR, counter 0, sda_t=1, busy=1.
- STOP in any state: go to IDLE, sda_t=1, busy=0, stop_det pulse. Partial byte discarded; ptr retained.
- START/STOP take priority over scl edges in the same cycle.
- Data sampled on scl_re, MSB first. SDA changes by the target only on scl_fe.
- States:
  - IDLE: wait for START.
  - DADDR: shift 8 bits. After the 8th bit: if byte[7:1]==DEV_ADDR, go to DADDR_ACK with rw=byte[0]; else go to IDLE with no drive. busy stays 1 until STOP.
  - DADDR_ACK: at next scl_fe, sda_t=0. At the following scl_fe, release. rw=0 -> MADDR. rw=1 -> RDATA, loading shifter from reg[ptr] and driving MSB on that same scl_fe.
  - MADDR: 8 bits. ptr <= byte[ADDR_W-1:0]; upper bits ignored. ACK as above, then -> WDATA.
  - WDATA: on 8th scl_re: reg[ptr]<=byte, wr_stb=1 for one clk with wr_addr=ptr, wr_data=byte. Then ptr <= ptr+1 mod NUM_REGS. ACK, then -> WDATA for the next byte. No NACK is ever issued for data.
  - RDATA: sda_t = current shifter MSB (1 releases), updated each scl_fe. After the 8th bit's scl_fe, sda_t=1 -> RDATA_ACK.
  - RDATA_ACK: sample SDA on scl_re.
    - 0 (ACK): ptr++ mod NUM_REGS; at scl_fe load reg[ptr] and drive MSB -> RDATA.
    - 1 (NACK): ptr++; go to WAIT (sda_t=1, ignore scl until START/STOP).
- Pointer wraps NUM_REGS-1 -> 0 on both read and write.
- Register updated on the same clk that wr_stb asserts; regs_o reflects it next cycle.
- Timing: the ACK drive asserts within SYNC_STAGES+2 clk of the bus scl falling edge.

Test Plan:
- Write burst: START, 0xA0, 0x02, 0x11, 0x22, 0x33, STOP -> sda_t=0 during each 9th SCL high (5 ACKs). wr_stb 3 pulses at addr 2/3/4 with data 0x11/0x22/0x33. regs[2..4]=11,22,33. stop_det 1 pulse, busy low after.
- Address mismatch: START, 0xA2, 0x05, STOP -> sda_t held 1 throughout, no wr_stb, regs unchanged, busy 1 until STOP.
- Read with repeated START after the write burst: START, 0xA0, 0x03, Sr, 0xA1, master ACK then NACK, STOP -> bus reads 0x22 then 0x33; ptr ends at 5.
- Wrap (ADDR_W=4): write 0x0F, 0xAA, 0xBB -> reg[15]=0xAA, reg[0]=0xBB, wr_addr 15 then 0.
- STOP after 4 data bits of a WDATA byte -> no wr_stb, reg unchanged, state IDLE, next transaction works normally.
- rst=0 asserted during RDATA while the target drives low -> sda_t=1 next clk, all regs 0, busy=0. A following transaction is decoded correctly.
